// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel filter.
package sobel_pkg;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_GX  = 2'd1;
  localparam logic [1:0] MODE_GY  = 2'd2;
  localparam logic [1:0] MODE_THR = 2'd3;

  // Signed gradient width: |G| <= 4*(2^pix_w-1), and |Gx|+|Gy| still fits unsigned.
  function automatic int grad_width(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row pixel history: on each advance, row_mid returns the pixel one row back
// and row_top the pixel two rows back, then both rows shift by one row.
module sobel_line_buffer #(
  parameter int IMG_W = 720,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [PIX_W-1:0] row_mid,
  output logic [PIX_W-1:0] row_top
);

  localparam int AW = $clog2(IMG_W);

  logic [PIX_W-1:0] mid_mem [IMG_W];
  logic [PIX_W-1:0] top_mem [IMG_W];
  logic [AW-1:0]    ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (advance)
      ptr <= (ptr == AW'(IMG_W - 1)) ? '0 : ptr + 1'b1;
  end

  // NOTE: the row memories have no reset; stale contents only ever reach border outputs.
  always_ff @(posedge clk) begin
    if (advance) begin
      mid_mem[ptr] <= pixel_in;
      top_mem[ptr] <= mid_mem[ptr];
    end
  end

  assign row_mid = mid_mem[ptr];
  assign row_top = top_mem[ptr];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter between an input and an output pixel FIFO;
// one output pixel per input pixel, IMG_W+1 accepted pixels of latency.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 720,
  parameter int IMG_H = 720,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [PIX_W-1:0] pixel_in,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [PIX_W-1:0] sobel_pixel,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  output logic             frame_done
);

  localparam int GW = grad_width(PIX_W);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t state, state_nxt;

  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic          in_last, out_last, fill_done;

  logic [1:0]       mode_q;
  logic [PIX_W-1:0] thresh_q;

  logic [PIX_W-1:0] lb_top, lb_mid;
  logic [PIX_W-1:0] t_q [2];
  logic [PIX_W-1:0] m_q [2];
  logic [PIX_W-1:0] b_q [2];

  assign in_last   = (in_row == RW'(IMG_H - 1)) && (in_col == CW'(IMG_W - 1));
  assign out_last  = (out_row == RW'(IMG_H - 1)) && (out_col == CW'(IMG_W - 1));
  assign fill_done = (in_row == RW'(1)) && (in_col == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    frame_done = 1'b0;
    if (!rst) begin
      case (state)
        FILL: begin
          in_rd_en = !in_empty;
          if (in_rd_en && fill_done) state_nxt = RUN;
        end
        RUN: begin
          in_rd_en  = !in_empty && !out_full;
          out_wr_en = in_rd_en;
          if (in_rd_en && in_last) state_nxt = FLUSH;
        end
        FLUSH: begin
          out_wr_en = !out_full;
          if (out_wr_en && out_last) begin
            frame_done = 1'b1;
            state_nxt  = FILL;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      in_col   <= '0;
      in_row   <= '0;
      out_col  <= '0;
      out_row  <= '0;
      mode_q   <= MODE_SUM;
      thresh_q <= '0;
    end else begin
      state <= state_nxt;
      if (in_rd_en) begin
        in_col <= (in_col == CW'(IMG_W - 1)) ? '0 : in_col + 1'b1;
        if (in_col == CW'(IMG_W - 1))
          in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + 1'b1;
      end
      if (out_wr_en) begin
        out_col <= (out_col == CW'(IMG_W - 1)) ? '0 : out_col + 1'b1;
        if (out_col == CW'(IMG_W - 1))
          out_row <= (out_row == RW'(IMG_H - 1)) ? '0 : out_row + 1'b1;
      end
      // Configuration tracks the inputs until the frame's first pixel is taken.
      if (state == FILL && in_row == '0 && in_col == '0) begin
        mode_q   <= mode;
        thresh_q <= thresh;
      end
    end
  end

  sobel_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .advance  (in_rd_en),
    .pixel_in (pixel_in),
    .row_mid  (lb_mid),
    .row_top  (lb_top)
  );

  // Window columns 0 and 1 are registered; column 2 is the live line-buffer/input column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= '{default: '0};
      m_q <= '{default: '0};
      b_q <= '{default: '0};
    end else if (in_rd_en) begin
      t_q <= '{t_q[1], lb_top};
      m_q <= '{m_q[1], lb_mid};
      b_q <= '{b_q[1], pixel_in};
    end
  end

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed(GW'(p));
  endfunction

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay, sum, sel;
  logic [PIX_W-1:0]     sat, pix_val;
  logic                 border;

  always_comb begin
    gx  = (ext(lb_top) + (ext(lb_mid) <<< 1) + ext(pixel_in))
        - (ext(t_q[0]) + (ext(m_q[0]) <<< 1) + ext(b_q[0]));
    gy  = (ext(t_q[0]) + (ext(t_q[1]) <<< 1) + ext(lb_top))
        - (ext(b_q[0]) + (ext(b_q[1]) <<< 1) + ext(pixel_in));
    ax  = $unsigned(gx[GW-1] ? -gx : gx);
    ay  = $unsigned(gy[GW-1] ? -gy : gy);
    sum = ax + ay;
    case (mode_q)
      MODE_GX: sel = ax;
      MODE_GY: sel = ay;
      default: sel = sum;
    endcase
    sat    = (|sel[GW-1:PIX_W]) ? '1 : sel[PIX_W-1:0];
    border = (out_row == '0) || (out_row == RW'(IMG_H - 1)) ||
             (out_col == '0) || (out_col == CW'(IMG_W - 1));
    if (border)
      pix_val = '0;
    else if (mode_q == MODE_THR)
      pix_val = (sum >= GW'(thresh_q)) ? '1 : '0;
    else
      pix_val = sat;
    sobel_pixel = out_wr_en ? pix_val : '0;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Parametrised streaming 3x3 Sobel edge filter for the image pipeline, successor to the fixed 720x720 8-bit Sobel stage. Sits between an input pixel FIFO and an output pixel FIFO. Reads one raster-order frame, writes exactly one output pixel per input pixel. Adds configurable image size and pixel width, four selectable output modes with binary thresholding, an explicit end-of-frame flush, and back-to-back frame support.

## Interface
- IMG_W, 720: pixels per row (>= 3)
- IMG_H, 720: rows per frame (>= 3)
- PIX_W, 8: bits per pixel, input and output
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_rd_en  out  1  pops pixel_in from the input FIFO this cycle
- in_empty  in  1  input FIFO empty
- pixel_in  in  PIX_W  input pixel, unsigned, raster order
- out_wr_en  out  1  pushes sobel_pixel into the output FIFO this cycle
- out_full  in  1  output FIFO full
- sobel_pixel  out  PIX_W  output pixel
- mode  in  2  0: |Gx|+|Gy|, 1: |Gx|, 2: |Gy|, 3: threshold of |Gx|+|Gy|
- thresh  in  PIX_W  threshold for mode 3
- frame_done  out  1  one-cycle pulse on the last output write of a frame

## Operation
- States: FILL, RUN, FLUSH. Reset enters FILL with all counters zero.
- FILL: in_rd_en = !in_empty. Consumes the first IMG_W+1 pixels of a frame into the two line buffers and window. out_wr_en = 0. Moves to RUN after pixel IMG_W+1 is consumed. mode and thresh are latched on FILL entry and held for the whole frame.
- RUN: step = !in_empty && !out_full. When step is true, in_rd_en = out_wr_en = 1. Consuming input index k writes output index k-(IMG_W+1). Moves to FLUSH after input index IMG_W*IMG_H-1 is consumed.
- FLUSH: in_rd_en = 0, out_wr_en = !out_full. Emits the remaining IMG_W+1 outputs. frame_done is high in the cycle of the final write. The block then returns to FILL, and the next frame's first pixel can be read the following cycle.
- Output (r,c) is 0 when r = 0, r = IMG_H-1, c = 0 or c = IMG_W-1.
- Interior outputs use the standard Sobel kernels on the true 3x3 neighbourhood:
  - Gx = right column − left column, weights 1,2,1
  - Gy = top row − bottom row, weights 1,2,1
- Arithmetic: Gx and Gy are signed, PIX_W+4 bits, and never overflow. Magnitudes are unsigned. mag = the mode-selected sum, saturated to 2^PIX_W−1.
- Mode 3: output is all-ones when |Gx|+|Gy| (unsaturated) >= thresh, else 0.
- No pixel is dropped or duplicated under any in_empty/out_full pattern. State, counters and window hold when the block is stalled.
- Reset mid-frame abandons the frame: line buffers are not cleared, counters return to zero, and the next pixel read is treated as pixel (0,0).

## Timing
- Reset values: in_rd_en=0, out_wr_en=0, sobel_pixel=0, frame_done=0.
- in_rd_en and out_wr_en are combinational from state, in_empty and out_full. No registered lookahead is allowed.
- sobel_pixel is combinational from window registers and counters. It is valid whenever out_wr_en=1 and is 0 whenever out_wr_en=0.
- Pipeline depth is IMG_W+1 accepted pixels, not cycles.
- Steady-state throughput is 1 pixel/cycle.
- Frame cost is IMG_W*IMG_H + IMG_W + 1 active cycles.
- Simultaneous empty and full in RUN: hold.

## Structure
- Package sobel_pkg:
  - state enum (FILL, RUN, FLUSH)
  - mode encodings (MODE_SUM, MODE_GX, MODE_GY, MODE_THR)
  - function for the gradient-width calculation
- Sub-module sobel_line_buffer: parametrised IMG_W x PIX_W dual-row buffer with a shift-on-advance, one read/write per step. It is instantiated once.
- Kernel math, saturation and mode mux stay in sobel_stream.

## Test plan
- Use IMG_W=8, IMG_H=6, PIX_W=8 for all scenarios.
- Constant image of 100, mode 0: exactly 48 writes, all 0; one frame_done pulse on write 48.
- Vertical edge, columns 0–3 = 0 and columns 4–7 = 200:
  - mode 0: interior columns 3 and 4 are 255 (Gx=800, saturated), all else 0.
  - mode 2: all 0.
- Ramp with pixel = 10·col:
  - mode 1: interior 80, border 0.
  - mode 3 with thresh=50: interior 255.
  - mode 3 with thresh=100: all 0.
- Back-to-back edge and ramp frames, with mode changed mid-frame: each frame is correct using the mode latched at its start; 96 writes; two frame_done pulses.
- Random 50% in_empty and 50% out_full on the edge frame: output sequence identical to the unstalled run; no read while empty; no write while full.
- Reset asserted after 20 reads, then a full constant frame: all outputs 0 during reset; the following frame gives 48 correct writes.
